cpu_stage_alu_unit: RTL and testbench

- Execution-control slice of the multi-cycle CPU.
- Contains the free-running stage sequencer (modulo-N counter), the ALU operand/opcode selection logic, and a combinational 32-bit ALU.
- Drives the stage index consumed by the fetch/issue register, PC register, memory control and register-file control.
- Produces the ALU result, used both as next-PC value and as register writeback data.

---
 rtl/cpu_stage_alu_unit_pkg.sv | 26 ++
 rtl/cpu_alu_core.sv | 40 ++++
 rtl/cpu_stage_alu_unit.sv | 80 ++++++++
 tb/tb_cpu_stage_alu_unit.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_stage_alu_unit_pkg.sv
// Shared constants for the execution-control slice of the multi-cycle CPU.
// Contents:
//   STAGE_*        stage index encodings driven by the sequencer
//   ALU_*          3-bit ALU opcode encodings
//   DATA_W_DEFAULT default datapath width
// Optional feature macro used by the ALU core: ALU_SHIFT_EN.
package cpu_stage_alu_unit_pkg;

  localparam int unsigned DATA_W_DEFAULT = 32;

  localparam int unsigned STAGE_INSTR_FETCH = 0;
  localparam int unsigned STAGE_DECODE      = 1;
  localparam int unsigned STAGE_EXECUTE     = 2;
  localparam int unsigned STAGE_WRITEBACK   = 3;
  localparam int unsigned STAGE_PC_UPDATE   = 4;

  localparam logic [2:0] ALU_AND = 3'd0;
  localparam logic [2:0] ALU_OR  = 3'd1;
  localparam logic [2:0] ALU_XOR = 3'd2;
  localparam logic [2:0] ALU_ADD = 3'd3;
  localparam logic [2:0] ALU_SUB = 3'd4;
  localparam logic [2:0] ALU_SHL = 3'd5;
  localparam logic [2:0] ALU_SHR = 3'd6;
  localparam logic [2:0] ALU_NOT = 3'd7;

endpackage

// File: rtl/cpu_alu_core.sv
// Pure combinational ALU, zero latency.
// Ports:
//   in0  operand 0
//   in1  operand 1 (shift amount taken from in1[4:0])
//   op   3-bit opcode (ALU_AND..ALU_NOT)
//   out  result, modulo 2^DATA_W
// Macro ALU_SHIFT_EN: when defined, SHL/SHR are implemented; otherwise the
// shifter is omitted and those opcodes return 0.
module cpu_alu_core
  import cpu_stage_alu_unit_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
  input  logic [DATA_W-1:0] in0,
  input  logic [DATA_W-1:0] in1,
  input  logic [2:0]        op,
  output logic [DATA_W-1:0] out
);

  always_comb begin
    out = '0;
    case (op)
      ALU_AND: out = in0 & in1;
      ALU_OR:  out = in0 | in1;
      ALU_XOR: out = in0 ^ in1;
      ALU_ADD: out = in0 + in1;
      ALU_SUB: out = in0 - in1;
`ifdef ALU_SHIFT_EN
      ALU_SHL: out = in0 << in1[4:0];
      ALU_SHR: out = in0 >> in1[4:0];
`else
      ALU_SHL: out = '0;
      ALU_SHR: out = '0;
`endif
      ALU_NOT: out = ~in0;
      default: out = '0;
    endcase
  end

endmodule

// File: rtl/cpu_stage_alu_unit.sv
// Execution-control slice: free-running stage sequencer, ALU operand/opcode
// selection and the combinational ALU.
// Ports:
//   clk, rst               clock and synchronous active-high reset
//   pc_value               current PC register output
//   alu_operation          decoded opcode of the issued instruction
//   reg_a, reg_b           register-file read data
//   stage                  current stage index
//   is_stage_instr_fetch   stage == STAGE_INSTR_FETCH
//   is_stage_pc_update     stage == STAGE_PC_UPDATE
//   alu_in0, alu_in1       selected operands
//   alu_op_select          selected opcode
//   alu_result             ALU output (next PC or writeback data)
// Macro ALU_SHIFT_EN enables the shifter inside cpu_alu_core.
module cpu_stage_alu_unit
  import cpu_stage_alu_unit_pkg::*;
#(
  parameter int unsigned NUM_STAGES = 5,
  parameter int unsigned STAGE_W    = 3,
  parameter int unsigned DATA_W     = DATA_W_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DATA_W-1:0]  pc_value,
  input  logic [2:0]         alu_operation,
  input  logic [DATA_W-1:0]  reg_a,
  input  logic [DATA_W-1:0]  reg_b,
  output logic [STAGE_W-1:0] stage,
  output logic               is_stage_instr_fetch,
  output logic               is_stage_pc_update,
  output logic [DATA_W-1:0]  alu_in0,
  output logic [DATA_W-1:0]  alu_in1,
  output logic [2:0]         alu_op_select,
  output logic [DATA_W-1:0]  alu_result
);

  logic [STAGE_W-1:0] stage_q, stage_d;

  // >= rather than == so any out-of-range value also returns to 0.
  always_comb begin
    stage_d = stage_q + STAGE_W'(1);
    if (stage_q >= STAGE_W'(NUM_STAGES - 1)) begin
      stage_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign stage                = stage_q;
  assign is_stage_instr_fetch = (stage_q == STAGE_W'(STAGE_INSTR_FETCH));
  assign is_stage_pc_update   = (stage_q == STAGE_W'(STAGE_PC_UPDATE));

  // PC is word-addressed, so the PC-update stage computes PC + 1.
  always_comb begin
    alu_in0       = reg_a;
    alu_in1       = reg_b;
    alu_op_select = alu_operation;
    if (is_stage_pc_update) begin
      alu_in0       = pc_value;
      alu_in1       = DATA_W'(1);
      alu_op_select = ALU_ADD;
    end
  end

  cpu_alu_core #(
    .DATA_W (DATA_W)
  ) u_alu_core (
    .in0 (alu_in0),
    .in1 (alu_in1),
    .op  (alu_op_select),
    .out (alu_result)
  );

endmodule

// File: tb/tb_cpu_stage_alu_unit.sv
// Self-checking bench for cpu_stage_alu_unit. Expected values are pushed to a
// scoreboard queue when stimulus is applied and popped when outputs are sampled.
// Honours ALU_SHIFT_EN for the shift expectations.
module tb_cpu_stage_alu_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_value;
  logic [2:0]  alu_operation;
  logic [31:0] reg_a;
  logic [31:0] reg_b;
  logic [2:0]  stage;
  logic        is_stage_instr_fetch;
  logic        is_stage_pc_update;
  logic [31:0] alu_in0;
  logic [31:0] alu_in1;
  logic [2:0]  alu_op_select;
  logic [31:0] alu_result;

  int unsigned passed = 0;
  int unsigned total  = 0;
  logic [31:0] exp_q[$];

  cpu_stage_alu_unit #(
    .NUM_STAGES (5),
    .STAGE_W    (3),
    .DATA_W     (32)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .pc_value             (pc_value),
    .alu_operation        (alu_operation),
    .reg_a                (reg_a),
    .reg_b                (reg_b),
    .stage                (stage),
    .is_stage_instr_fetch (is_stage_instr_fetch),
    .is_stage_pc_update   (is_stage_pc_update),
    .alu_in0              (alu_in0),
    .alu_in1              (alu_in1),
    .alu_op_select        (alu_op_select),
    .alu_result           (alu_result)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Called at a negedge; returns ok=1 once stage equals target (bounded).
  task automatic wait_stage(input logic [2:0] target, output bit ok);
    int n;
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 12) begin
      if (stage === target) ok = 1'b1;
      else begin
        @(negedge clk);
        n++;
      end
    end
  endtask

  task automatic test_reset();
    logic [31:0] e;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if (stage !== 3'd0) $display("FAIL reset_stage got %0d want 0", stage);
    else passed++;
    total++;
    if (is_stage_instr_fetch !== 1'b1)
      $display("FAIL reset_fetch_flag got %b want 1", is_stage_instr_fetch);
    else passed++;
    total++;
    if (is_stage_pc_update !== 1'b0)
      $display("FAIL reset_pc_flag got %b want 0", is_stage_pc_update);
    else passed++;
    rst = 1'b0;
    exp_q.push_back(32'd1); exp_q.push_back(32'd2); exp_q.push_back(32'd3);
    exp_q.push_back(32'd4); exp_q.push_back(32'd0); exp_q.push_back(32'd1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      total++;
      if (stage !== e[2:0]) $display("FAIL seq_stage[%0d] got %0d want %0d", i, stage, e);
      else passed++;
      total++;
      if (is_stage_pc_update !== (e == 32'd4))
        $display("FAIL seq_pc_flag[%0d] got %b want %b", i, is_stage_pc_update, (e == 32'd4));
      else passed++;
      total++;
      if (is_stage_instr_fetch !== (e == 32'd0))
        $display("FAIL seq_fetch_flag[%0d] got %b want %b", i, is_stage_instr_fetch,
                 (e == 32'd0));
      else passed++;
    end
  endtask

  task automatic test_mid_reset();
    bit ok;
    logic [31:0] e;
    wait_stage(3'd3, ok);
    total++;
    if (!ok) $display("FAIL mid_reset_wait got timeout want stage 3");
    else passed++;
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (stage !== 3'd0) $display("FAIL mid_reset_stage got %0d want 0", stage);
    else passed++;
    rst = 1'b0;
    exp_q.push_back(32'd1); exp_q.push_back(32'd2);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      total++;
      if (stage !== e[2:0]) $display("FAIL restart_stage[%0d] got %0d want %0d", i, stage, e);
      else passed++;
    end
  endtask

  task automatic test_pc_increment();
    bit ok;
    logic [31:0] e;
    wait_stage(3'd4, ok);
    total++;
    if (!ok) $display("FAIL pc_wait got timeout want stage 4");
    else passed++;
    pc_value = 32'h0000_0007; alu_operation = 3'd0;
    reg_a = 32'hDEAD_BEEF; reg_b = 32'h1234_5678;
    exp_q.push_back(32'h0000_0007); exp_q.push_back(32'h1);
    exp_q.push_back(32'h3); exp_q.push_back(32'h0000_0008);
    #1;
    e = exp_q.pop_front(); total++;
    if (alu_in0 !== e) $display("FAIL pc_in0 got %h want %h", alu_in0, e);
    else passed++;
    e = exp_q.pop_front(); total++;
    if (alu_in1 !== e) $display("FAIL pc_in1 got %h want %h", alu_in1, e);
    else passed++;
    e = exp_q.pop_front(); total++;
    if (alu_op_select !== e[2:0]) $display("FAIL pc_op got %0d want %0d", alu_op_select, e);
    else passed++;
    e = exp_q.pop_front(); total++;
    if (alu_result !== e) $display("FAIL pc_inc got %h want %h", alu_result, e);
    else passed++;
    pc_value = 32'hFFFF_FFFF;
    exp_q.push_back(32'h0000_0000);
    #1;
    e = exp_q.pop_front(); total++;
    if (alu_result !== e) $display("FAIL pc_wrap got %h want %h", alu_result, e);
    else passed++;
  endtask

  task automatic test_reg_ops();
    logic [2:0]  ops  [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd7};
    logic [31:0] wants[6] = '{32'h30, 32'hFC, 32'hCC, 32'h12C, 32'hB4, 32'hFFFF_FF0F};
    bit ok;
    logic [31:0] e;
    for (int i = 0; i < 6; i++) begin
      wait_stage(3'd2, ok);
      total++;
      if (!ok) $display("FAIL reg_wait[%0d] got timeout want stage 2", i);
      else passed++;
      reg_a = 32'h0000_00F0; reg_b = 32'h0000_003C; alu_operation = ops[i];
      pc_value = 32'h5555_5555;
      exp_q.push_back(wants[i]);
      #1;
      e = exp_q.pop_front();
      total++;
      if (alu_result !== e) $display("FAIL reg_op%0d got %h want %h", ops[i], alu_result, e);
      else passed++;
      total++;
      if (alu_op_select !== ops[i])
        $display("FAIL reg_opsel%0d got %0d want %0d", ops[i], alu_op_select, ops[i]);
      else passed++;
      @(negedge clk);
    end
  endtask

  task automatic test_sub_wrap();
    bit ok;
    logic [31:0] e;
    wait_stage(3'd2, ok);
    total++;
    if (!ok) $display("FAIL sub_wait got timeout want stage 2");
    else passed++;
    reg_a = 32'h0; reg_b = 32'h1; alu_operation = 3'd4;
    exp_q.push_back(32'hFFFF_FFFF);
    #1;
    e = exp_q.pop_front(); total++;
    if (alu_result !== e) $display("FAIL sub_wrap got %h want %h", alu_result, e);
    else passed++;
    @(negedge clk);
  endtask

  task automatic test_shifts();
    bit ok;
    logic [31:0] e;
    wait_stage(3'd1, ok);
    total++;
    if (!ok) $display("FAIL shift_wait got timeout want stage 1");
    else passed++;
    reg_a = 32'h8000_0001; reg_b = 32'd4;
`ifdef ALU_SHIFT_EN
    exp_q.push_back(32'h0000_0010); exp_q.push_back(32'h0800_0000);
`else
    exp_q.push_back(32'h0); exp_q.push_back(32'h0);
`endif
    alu_operation = 3'd5;
    #1;
    e = exp_q.pop_front(); total++;
    if (alu_result !== e) $display("FAIL shl got %h want %h", alu_result, e);
    else passed++;
    alu_operation = 3'd6;
    #1;
    e = exp_q.pop_front(); total++;
    if (alu_result !== e) $display("FAIL shr got %h want %h", alu_result, e);
    else passed++;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; pc_value = '0; alu_operation = '0; reg_a = '0; reg_b = '0;
    test_reset();
    test_mid_reset();
    test_pc_increment();
    test_reg_ops();
    test_sub_wrap();
    test_shifts();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
